// File: rtl/register_file.sv
// Register file with two combinational read ports, one clocked write port,
// a hardwired-zero entry 0 and a same-cycle write-to-read bypass.
module register_file #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DEPTH      = 2**ADDR_WIDTH
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic [ADDR_WIDTH-1:0] ReadReg1,
   input  logic [ADDR_WIDTH-1:0] ReadReg2,
   input  logic [ADDR_WIDTH-1:0] WriteReg,
   input  logic [DATA_WIDTH-1:0] WriteData,
   input  logic                  RegWrite,
   output logic [DATA_WIDTH-1:0] ReadData1,
   output logic [DATA_WIDTH-1:0] ReadData2
);

   logic [DATA_WIDTH-1:0] regs [DEPTH];
   logic                  wr_en;

   // Writes to entry 0 are dropped, so it stays at its reset value of zero.
   assign wr_en = RegWrite && (WriteReg != '0);

   // Storage; cleared asynchronously on reset.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en) begin
         regs[WriteReg] <= WriteData;
      end
   end

   // Read port 1: zero for entry 0 or reset, bypass on a matching write.
   always_comb begin
      ReadData1 = '0;
      if (Reset_n && (ReadReg1 != '0)) begin
         if (RegWrite && (WriteReg == ReadReg1)) begin
            ReadData1 = WriteData;
         end else begin
            ReadData1 = regs[ReadReg1];
         end
      end
   end

   // Read port 2: same rules as port 1.
   always_comb begin
      ReadData2 = '0;
      if (Reset_n && (ReadReg2 != '0)) begin
         if (RegWrite && (WriteReg == ReadReg2)) begin
            ReadData2 = WriteData;
         end else begin
            ReadData2 = regs[ReadReg2];
         end
      end
   end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed vector table plus
// hand-written reset, sweep and reset-during-write sequences.
module tb_register_file;

   logic        Clk;
   logic        Reset_n;
   logic [4:0]  ReadReg1;
   logic [4:0]  ReadReg2;
   logic [4:0]  WriteReg;
   logic [31:0] WriteData;
   logic        RegWrite;
   logic [31:0] ReadData1;
   logic [31:0] ReadData2;

   int tests;
   int fails;

   typedef struct {
      logic        we;
      logic [4:0]  wr;
      logic [31:0] wd;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic [31:0] e1;
      logic [31:0] e2;
   } vec_t;

   vec_t vecs [11];

   register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .ReadReg1  (ReadReg1),
      .ReadReg2  (ReadReg2),
      .WriteReg  (WriteReg),
      .WriteData (WriteData),
      .RegWrite  (RegWrite),
      .ReadData1 (ReadData1),
      .ReadData2 (ReadData2)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      Reset_n   = 1'b0;
      RegWrite  = 1'b0;
      WriteReg  = 5'd0;
      WriteData = 32'd0;
      ReadReg1  = 5'd1;
      ReadReg2  = 5'd2;

      // Vector table: inputs driven after negedge, outputs checked before posedge.
      vecs[0]  = '{1'b1, 5'd2, 32'd2,        5'd2, 5'd3, 32'd2,        32'd0};
      vecs[1]  = '{1'b1, 5'd3, 32'd3,        5'd2, 5'd3, 32'd2,        32'd3};
      vecs[2]  = '{1'b0, 5'd2, 32'hFFFFFFFF, 5'd2, 5'd3, 32'd2,        32'd3};
      vecs[3]  = '{1'b0, 5'd3, 32'hFFFFFFFF, 5'd3, 5'd2, 32'd3,        32'd2};
      vecs[4]  = '{1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 32'd0,        32'd0};
      vecs[5]  = '{1'b0, 5'd0, 32'h12345678, 5'd0, 5'd0, 32'd0,        32'd0};
      vecs[6]  = '{1'b1, 5'd4, 32'd4,        5'd1, 5'd2, 32'd0,        32'd2};
      vecs[7]  = '{1'b1, 5'd4, 32'd44,       5'd4, 5'd4, 32'd44,       32'd44};
      vecs[8]  = '{1'b0, 5'd4, 32'd0,        5'd4, 5'd4, 32'd44,       32'd44};
      vecs[9]  = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd4, 32'hDEADBEEF, 32'd44};
      vecs[10] = '{1'b0, 5'd5, 32'd0,        5'd5, 5'd3, 32'hDEADBEEF, 32'd3};

      #1;
      chk("reset_rd1", ReadData1, 32'd0);
      chk("reset_rd2", ReadData2, 32'd0);
      @(negedge Clk);
      Reset_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         @(negedge Clk);
         RegWrite  = vecs[i].we;
         WriteReg  = vecs[i].wr;
         WriteData = vecs[i].wd;
         ReadReg1  = vecs[i].r1;
         ReadReg2  = vecs[i].r2;
         #2;
         chk($sformatf("vec%0d_rd1", i), ReadData1, vecs[i].e1);
         chk($sformatf("vec%0d_rd2", i), ReadData2, vecs[i].e2);
      end

      // Asynchronous reset pulse between edges, no clock involved.
      @(negedge Clk);
      RegWrite = 1'b0;
      ReadReg1 = 5'd5;
      ReadReg2 = 5'd4;
      #1;
      chk("pre_pulse_r5", ReadData1, 32'hDEADBEEF);
      Reset_n = 1'b0;
      #1;
      chk("pulse_r5", ReadData1, 32'd0);
      chk("pulse_r4", ReadData2, 32'd0);
      Reset_n = 1'b1;
      #1;
      chk("post_pulse_r5", ReadData1, 32'd0);
      chk("post_pulse_r4", ReadData2, 32'd0);

      // Full sweep: write addr*3 to 1..31, then read across both ports.
      for (int a = 1; a < 32; a++) begin
         @(negedge Clk);
         RegWrite  = 1'b1;
         WriteReg  = 5'(a);
         WriteData = 32'(a * 3);
      end
      @(negedge Clk);
      RegWrite = 1'b0;
      for (int a = 0; a < 32; a++) begin
         ReadReg1 = 5'(a);
         ReadReg2 = 5'(31 - a);
         #1;
         chk($sformatf("sweep_rd1_a%0d", a), ReadData1, 32'(a * 3));
         chk($sformatf("sweep_rd2_a%0d", 31 - a), ReadData2, 32'((31 - a) * 3));
      end
      ReadReg1 = 5'd31;
      ReadReg2 = 5'd0;
      #1;
      chk("sweep_r31", ReadData1, 32'd93);
      chk("sweep_r0", ReadData2, 32'd0);

      // Reset held across an edge with a write pending: write must be lost.
      @(negedge Clk);
      Reset_n   = 1'b0;
      RegWrite  = 1'b1;
      WriteReg  = 5'd7;
      WriteData = 32'd77;
      ReadReg1  = 5'd7;
      ReadReg2  = 5'd7;
      #1;
      chk("rstwr_bypass_off_rd1", ReadData1, 32'd0);
      chk("rstwr_bypass_off_rd2", ReadData2, 32'd0);
      @(negedge Clk);
      RegWrite = 1'b0;
      Reset_n  = 1'b1;
      ReadReg2 = 5'd31;
      #1;
      chk("rstwr_r7", ReadData1, 32'd0);
      chk("rstwr_r31", ReadData2, 32'd0);

      // First write after release is accepted on the next edge.
      @(negedge Clk);
      RegWrite  = 1'b1;
      WriteReg  = 5'd7;
      WriteData = 32'd77;
      @(negedge Clk);
      RegWrite = 1'b0;
      #1;
      chk("after_release_r7", ReadData1, 32'd77);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
